// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the load-use hazard / stall controller:
//   - MIPS opcode constants for instructions that read rt
//   - hz_state_t : stall FSM state encoding
//   - hz_ctrl_t  : packed pipeline control word {pc_write, ifid_write,
//                  bubble, freeze} and its three legal values
//   - LOAD_LAT_MAX : largest load latency the 3-bit counter can hold
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int LOAD_LAT_MAX = 7;
    localparam int HOLD_CNT_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_LU_HOLD = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic bubble;
        logic freeze;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE   = 4'b1100;
    localparam hz_ctrl_t CTRL_STALL  = 4'b0010;
    localparam hz_ctrl_t CTRL_FREEZE = 4'b0001;

    // Instructions whose rt field is a source operand (R-type, branches, store).
    function automatic logic op_uses_rt(input logic [5:0] op);
        logic uses_s;
        case (op)
            OP_RTYPE: uses_s = 1'b1;
            OP_BEQ:   uses_s = 1'b1;
            OP_BNE:   uses_s = 1'b1;
            OP_SW:    uses_s = 1'b1;
            default:  uses_s = 1'b0;
        endcase
        return uses_s;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Combinational load-use comparator. Flags a hazard when the instruction in
// EX is a load whose destination is a real register (not $0) and that
// register is read by the instruction in ID, either as rs or, for opcodes
// that actually source rt, as rt.
// Ports:
//   mem_read  in  1           instruction in EX is a load
//   load_rt   in  REG_ADDR_W  destination register of that load
//   op        in  6           opcode of the ID instruction
//   rs        in  5           rs field of the ID instruction
//   rt        in  5           rt field of the ID instruction
//   hit       out 1           load-use hazard detected
// ---------------------------------------------------------------------------
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] load_rt,
    input  logic [5:0]            op,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    output logic                  hit
);

    logic [REG_ADDR_W-1:0] rs_s;
    logic [REG_ADDR_W-1:0] rt_s;
    logic                  uses_rt_s;
    logic                  rs_match_s;
    logic                  rt_match_s;

    // Field alignment to the register-address width and per-operand match.
    always_comb begin
        rs_s       = REG_ADDR_W'(rs);
        rt_s       = REG_ADDR_W'(rt);
        uses_rt_s  = op_uses_rt(op);
        rs_match_s = (load_rt == rs_s);
        rt_match_s = (load_rt == rt_s) && uses_rt_s;
    end

    // Hazard decision; writes to $0 are discarded so they never create a dependency.
    always_comb begin
        if (mem_read && (load_rt != {REG_ADDR_W{1'b0}}) && (rs_match_s || rt_match_s)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Load-use hazard and stall controller for the 5-stage MIPS pipeline, in ID.
// A detected hazard stalls the front end (PC and IF/ID held, NOP bubble into
// ID/EX) for LOAD_LAT cycles: the first cycle is driven combinationally by
// the comparator, the remaining LOAD_LAT-1 cycles by the LU_HOLD counter,
// since the load has left EX by then. A busy data memory freezes the whole
// pipeline and takes priority; the stall FSM holds while frozen.
//
// Optional feature (macro HAZARD_STATS_EN): saturating counters of bubble
// cycles and freeze cycles. Without the macro both count ports read zero.
//
// Parameters:
//   REG_ADDR_W  register address width
//   LOAD_LAT    stall cycles per load-use hazard (1..7, clamped)
//   CNT_W       statistics counter width
// Ports:
//   clk_i              in  1           clock, rising edge
//   rst_i              in  1           synchronous active-high reset
//   IDEX_MemRead_i     in  1           instruction in EX is a load
//   IDEX_RegisterRt_i  in  REG_ADDR_W  destination of that load
//   instr_i            in  32          instruction in ID
//   dmem_busy_i        in  1           data memory access outstanding
//   pc_write_o         out 1           PC write enable
//   ifid_write_o       out 1           IF/ID write enable
//   bubble_o           out 1           insert NOP control word into ID/EX
//   freeze_o           out 1           hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles_o     out CNT_W       bubble cycle count
//   freeze_cycles_o    out CNT_W       freeze cycle count
// ---------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RegisterRt_i,
    input  logic [31:0]           instr_i,
    input  logic                  dmem_busy_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  bubble_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      freeze_cycles_o
);

    // Out-of-range latencies are clamped so the 3-bit counter can never wrap.
    localparam int LAT_EFF = (LOAD_LAT < 1) ? 1 :
                             ((LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT);
    localparam logic [HOLD_CNT_W-1:0] CNT_LOAD   = HOLD_CNT_W'(LAT_EFF - 1);
    localparam logic                  MULTI_CYC  = (LAT_EFF > 1) ? 1'b1 : 1'b0;

    hz_state_t             state_r;
    logic [HOLD_CNT_W-1:0] cnt_r;
    logic                  hit_s;
    hz_ctrl_t              ctrl_s;
    logic                  unused_instr_s;

    // Immediate / shamt / funct bits play no part in hazard detection.
    assign unused_instr_s = ^instr_i[15:0];

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_match (
        .mem_read (IDEX_MemRead_i),
        .load_rt  (IDEX_RegisterRt_i),
        .op       (instr_i[31:26]),
        .rs       (instr_i[25:21]),
        .rt       (instr_i[20:16]),
        .hit      (hit_s)
    );

    // Control word: reset forces idle, freeze beats stall, IDLE hit path is Mealy.
    always_comb begin
        ctrl_s = CTRL_IDLE;
        if (rst_i) begin
            ctrl_s = CTRL_IDLE;
        end else if (dmem_busy_i) begin
            ctrl_s = CTRL_FREEZE;
        end else if (state_r == ST_LU_HOLD) begin
            ctrl_s = CTRL_STALL;
        end else if (hit_s) begin
            ctrl_s = CTRL_STALL;
        end else begin
            ctrl_s = CTRL_IDLE;
        end
    end

    assign pc_write_o   = ctrl_s.pc_write;
    assign ifid_write_o = ctrl_s.ifid_write;
    assign bubble_o     = ctrl_s.bubble;
    assign freeze_o     = ctrl_s.freeze;

    // Stall FSM: cnt_r holds the stall cycles still owed, including the current one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {HOLD_CNT_W{1'b0}};
        end else if (dmem_busy_i) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_s && MULTI_CYC) begin
                        state_r <= ST_LU_HOLD;
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {HOLD_CNT_W{1'b0}};
                    end
                end
                ST_LU_HOLD: begin
                    // A zero count here is corrupt state; leave the hold rather than wrap.
                    if (cnt_r <= 3'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {HOLD_CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_LU_HOLD;
                        cnt_r   <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {HOLD_CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] freeze_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r_s;
        if (v == CNT_MAX) begin
            r_s = v;
        end else begin
            r_s = v + CNT_W'(1'b1);
        end
        return r_s;
    endfunction

    // Saturating statistics, counted from the control word actually driven.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            freeze_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ctrl_s.bubble) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ctrl_s.freeze) begin
                freeze_cnt_r <= sat_inc(freeze_cnt_r);
            end else begin
                freeze_cnt_r <= freeze_cnt_r;
            end
        end
    end

    assign stall_cycles_o  = stall_cnt_r;
    assign freeze_cycles_o = freeze_cnt_r;
`else
    assign stall_cycles_o  = {CNT_W{1'b0}};
    assign freeze_cycles_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
// Four instances (LOAD_LAT = 1..4) share one stimulus stream. Each cycle
// every instance is compared with a reference model that tracks only
// "stall cycles still owed" and the statistics totals. A vector table
// exercises the single-cycle decode on the LOAD_LAT=1 instance, hand
// sequences cover the multi-cycle corners, and random traffic follows.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam logic [3:0] E_IDLE  = 4'b1100;
    localparam logic [3:0] E_STALL = 4'b0010;
    localparam logic [3:0] E_FRZ   = 4'b0001;
`ifdef HAZARD_STATS_EN
    localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STATS_MASK = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic [4:0]  load_rt;
    logic [31:0] instr;
    logic        busy;

    logic [3:0]  outv [4];
    logic [31:0] scv  [4];
    logic [31:0] fcv  [4];

    int tests;
    int fails;

    // model state
    int rem   [4];
    int m_sc  [4];
    int m_fc  [4];
    logic [3:0]  obs    [4];
    logic [31:0] obs_sc [4];
    logic [31:0] obs_fc [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic pw, iw, bw, fw;
        logic [31:0] sc, fc;
        hazard_stall_unit #(
            .REG_ADDR_W (5),
            .LOAD_LAT   (g + 1),
            .CNT_W      (32)
        ) u_dut (
            .clk_i             (clk),
            .rst_i             (rst),
            .IDEX_MemRead_i    (mem_read),
            .IDEX_RegisterRt_i (load_rt),
            .instr_i           (instr),
            .dmem_busy_i       (busy),
            .pc_write_o        (pw),
            .ifid_write_o      (iw),
            .bubble_o          (bw),
            .freeze_o          (fw),
            .stall_cycles_o    (sc),
            .freeze_cycles_o   (fc)
        );
        assign outv[g] = {pw, iw, bw, fw};
        assign scv[g]  = sc;
        assign fcv[g]  = fc;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Load-use rule stated directly from the instruction fields.
    function automatic bit ref_hit(input bit mr, input logic [4:0] lrt, input logic [31:0] ins);
        logic [5:0] op;
        bit reads_rt;
        op = ins[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        return mr && (lrt != 5'd0) && ((lrt == ins[25:21]) || (reads_rt && lrt == ins[20:16]));
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d got %0h want %0h", nm, d, got, want);
        end
    endtask

    // One clock: drive, sample at the falling edge vs. model, advance model on the rising edge.
    task automatic step(input bit r, input bit mr, input logic [4:0] lrt,
                        input logic [31:0] ins, input bit b);
        bit h;
        logic [3:0] e [4];
        int nrem [4];
        rst = r; mem_read = mr; load_rt = lrt; instr = ins; busy = b;
        @(negedge clk);
        h = ref_hit(mr, lrt, ins);
        for (int d = 0; d < 4; d++) begin
            if (r) begin
                e[d] = E_IDLE; nrem[d] = 0;
            end else if (b) begin
                e[d] = E_FRZ; nrem[d] = rem[d];
            end else if (rem[d] > 0) begin
                e[d] = E_STALL; nrem[d] = rem[d] - 1;
            end else if (h) begin
                e[d] = E_STALL; nrem[d] = d;   // LOAD_LAT-1 cycles still owed
            end else begin
                e[d] = E_IDLE; nrem[d] = 0;
            end
            obs[d]    = outv[d];
            obs_sc[d] = scv[d];
            obs_fc[d] = fcv[d];
            chk("model_ctrl", d, {28'd0, outv[d]}, {28'd0, e[d]});
            chk("model_stall_cnt", d, scv[d], 32'(m_sc[d]) & STATS_MASK);
            chk("model_freeze_cnt", d, fcv[d], 32'(m_fc[d]) & STATS_MASK);
        end
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            rem[d] = nrem[d];
            if (r) begin
                m_sc[d] = 0; m_fc[d] = 0;
            end else begin
                if (e[d] == E_STALL) m_sc[d] = m_sc[d] + 1;
                if (e[d] == E_FRZ)   m_fc[d] = m_fc[d] + 1;
            end
        end
        #1;
    endtask

    typedef struct {
        bit          mr;
        logic [4:0]  lrt;
        logic [31:0] ins;
        bit          b;
        logic [3:0]  exp1;
    } vec_t;

    vec_t tbl [11];
    logic [31:0] add_i;
    logic [31:0] idle_i;
    logic [5:0]  ops [6];

    initial begin
        tests = 0; fails = 0;
        for (int d = 0; d < 4; d++) begin
            rem[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
        end
        add_i  = rtype(5'd2, 5'd4, 5'd3);          // add $3,$2,$4
        idle_i = rtype(5'd7, 5'd7, 5'd7);
        ops    = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};

        tbl[0]  = '{1'b1, 5'd2, add_i, 1'b0, E_STALL};
        tbl[1]  = '{1'b1, 5'd0, rtype(5'd0, 5'd0, 5'd1), 1'b0, E_IDLE};       // $0 filtered
        tbl[2]  = '{1'b1, 5'd5, itype(6'h08, 5'd1, 5'd5, 16'd1), 1'b0, E_IDLE}; // addi: rt is dest
        tbl[3]  = '{1'b1, 5'd5, itype(6'h2B, 5'd1, 5'd5, 16'd0), 1'b0, E_STALL}; // sw reads rt
        tbl[4]  = '{1'b1, 5'd5, itype(6'h04, 5'd1, 5'd5, 16'd4), 1'b0, E_STALL}; // beq
        tbl[5]  = '{1'b1, 5'd5, itype(6'h05, 5'd1, 5'd5, 16'd4), 1'b0, E_STALL}; // bne
        tbl[6]  = '{1'b0, 5'd2, add_i, 1'b0, E_IDLE};                            // not a load
        tbl[7]  = '{1'b1, 5'd2, add_i, 1'b1, E_FRZ};                             // freeze wins
        tbl[8]  = '{1'b0, 5'd2, add_i, 1'b1, E_FRZ};
        tbl[9]  = '{1'b1, 5'd5, itype(6'h23, 5'd5, 5'd2, 16'd0), 1'b0, E_STALL}; // lw rs match
        tbl[10] = '{1'b1, 5'd5, rtype(5'd1, 5'd5, 5'd6), 1'b0, E_STALL};         // R-type rt

        step(1'b1, 1'b0, 5'd0, idle_i, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].mr, tbl[i].lrt, tbl[i].ins, tbl[i].b);
            chk("table", 0, {28'd0, obs[0]}, {28'd0, tbl[i].exp1});
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 5'd0, idle_i, 1'b0);

        // Reset forces idle even with a hazard present; LOAD_LAT 1 and 3, freeze mid-stall.
        step(1'b1, 1'b1, 5'd2, add_i, 1'b0);
        for (int d = 0; d < 4; d++) chk("reset_idle", d, {28'd0, obs[d]}, {28'd0, E_IDLE});
        step(1'b0, 1'b1, 5'd2, add_i, 1'b0);
        chk("lat1_stall", 0, {28'd0, obs[0]}, {28'd0, E_STALL});
        chk("lat3_stall1", 2, {28'd0, obs[2]}, {28'd0, E_STALL});
        chk("cnt_after_reset", 2, obs_sc[2], 32'd0);
        step(1'b0, 1'b0, 5'd2, add_i, 1'b1);
        chk("lat3_freeze1", 2, {28'd0, obs[2]}, {28'd0, E_FRZ});
        step(1'b0, 1'b0, 5'd2, add_i, 1'b1);
        chk("lat3_freeze2", 2, {28'd0, obs[2]}, {28'd0, E_FRZ});
        step(1'b0, 1'b0, 5'd2, add_i, 1'b0);
        chk("lat3_stall2", 2, {28'd0, obs[2]}, {28'd0, E_STALL});
        chk("lat1_release", 0, {28'd0, obs[0]}, {28'd0, E_IDLE});
        step(1'b0, 1'b0, 5'd2, add_i, 1'b0);
        chk("lat3_stall3", 2, {28'd0, obs[2]}, {28'd0, E_STALL});
        step(1'b0, 1'b0, 5'd2, add_i, 1'b0);
        chk("lat3_release", 2, {28'd0, obs[2]}, {28'd0, E_IDLE});
        chk("lat3_stall_total", 2, obs_sc[2], 32'd3 & STATS_MASK);
        chk("lat3_freeze_total", 2, obs_fc[2], 32'd2 & STATS_MASK);

        // LOAD_LAT 4: reset in the 2nd stall cycle aborts the sequence.
        step(1'b1, 1'b0, 5'd0, idle_i, 1'b0);
        step(1'b0, 1'b1, 5'd2, add_i, 1'b0);
        chk("lat4_stall1", 3, {28'd0, obs[3]}, {28'd0, E_STALL});
        step(1'b1, 1'b0, 5'd0, idle_i, 1'b0);
        chk("lat4_in_reset", 3, {28'd0, obs[3]}, {28'd0, E_IDLE});
        step(1'b0, 1'b0, 5'd0, idle_i, 1'b0);
        chk("lat4_after_reset", 3, {28'd0, obs[3]}, {28'd0, E_IDLE});
        step(1'b0, 1'b0, 5'd0, idle_i, 1'b0);
        chk("lat4_stays_idle", 3, {28'd0, obs[3]}, {28'd0, E_IDLE});

        // LOAD_LAT 2: back-to-back hazards give four contiguous stall cycles.
        step(1'b1, 1'b0, 5'd0, idle_i, 1'b0);
        step(1'b0, 1'b1, 5'd2, add_i, 1'b0);
        chk("b2b_c1", 1, {28'd0, obs[1]}, {28'd0, E_STALL});
        step(1'b0, 1'b0, 5'd2, add_i, 1'b0);
        chk("b2b_c2", 1, {28'd0, obs[1]}, {28'd0, E_STALL});
        step(1'b0, 1'b1, 5'd3, rtype(5'd3, 5'd1, 5'd4), 1'b0);
        chk("b2b_c3", 1, {28'd0, obs[1]}, {28'd0, E_STALL});
        step(1'b0, 1'b0, 5'd3, add_i, 1'b0);
        chk("b2b_c4", 1, {28'd0, obs[1]}, {28'd0, E_STALL});
        step(1'b0, 1'b0, 5'd0, idle_i, 1'b0);
        chk("b2b_release", 1, {28'd0, obs[1]}, {28'd0, E_IDLE});

        // Random traffic, all instances checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            bit r, mr, b;
            logic [4:0] lrt, rs, rt;
            logic [5:0] op;
            r   = ($urandom_range(99, 0) < 3);
            mr  = ($urandom_range(1, 0) == 1);
            b   = ($urandom_range(99, 0) < 20);
            lrt = 5'($urandom_range(7, 0));
            rs  = 5'($urandom_range(7, 0));
            rt  = 5'($urandom_range(7, 0));
            op  = ops[$urandom_range(5, 0)];
            step(r, mr, lrt, {op, rs, rt, 16'($urandom())}, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
